twiddle_modexp: RTL and testbench

- Sequential modular exponentiation engine that computes result = base^exp mod P for the NTT twiddle-factor table fill logic.
- Sits directly upstream of the table builder and supplies the special modexp entries, e.g. omega^k mod p.
- Uses square-and-multiply over a bit-serial interleaved modular multiplier, so there is no wide multiplier.
- Latency is deterministic, which simplifies scheduling and verification.

---
 rtl/ntt_pkg.sv | 22 ++
 rtl/mod_mul_serial.sv | 71 +++++++
 rtl/twiddle_modexp.sv | 175 +++++++++++++++++
 tb/tb_twiddle_modexp.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants and the modexp FSM state type.
package ntt_pkg;

  // Operand/result width and exponent width used by the twiddle datapath.
  localparam int NTT_W     = 64;
  localparam int NTT_EXP_W = 16;

  // Field modulus, primitive root and two-adicity of the NTT field.
  localparam logic [63:0] NTT_P     = 64'd4179340454199820289;
  localparam logic [63:0] NTT_OMEGA = 64'd68630377364883;
  localparam int          NTT_M     = 57;

  // Modular exponentiation sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    SQR    = 3'd2,
    MUL    = 3'd3,
    FIN    = 3'd4
  } modexp_state_e;

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: p_out = (a * b) mod P.
// Requires a < P and P < 2^(W-1); b may be any W-bit value.
// A start pulse loads the operands; W iteration cycles follow, one bit of b
// each, MSB first. done is high in the last iteration cycle, W cycles after
// start, and p_out carries the final product combinationally in that cycle
// only, so the consumer captures it on the same clock edge.
module mod_mul_serial #(
  parameter int          W = 64,
  parameter logic [W-1:0] P = 64'd4179340454199820289
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] p_out
);

  localparam int         CNT_W = $clog2(W + 1);
  localparam logic [W:0] P_EXT = {1'b0, P};

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  logic [W:0]   t_dbl;
  logic [W-1:0] t_dbl_r;
  logic [W-1:0] addend;
  logic [W:0]   t_add;
  logic [W-1:0] t_add_r;

  // One interleaved step: double, reduce, conditionally add a, reduce.
  always_comb begin
    t_dbl   = {acc_q, 1'b0};
    t_dbl_r = (t_dbl >= P_EXT) ? W'(t_dbl - P_EXT) : W'(t_dbl);
    addend  = b_q[W-1] ? a_q : '0;
    t_add   = {1'b0, t_dbl_r} + {1'b0, addend};
    t_add_r = (t_add >= P_EXT) ? W'(t_add - P_EXT) : W'(t_add);
  end

  assign done  = active_q && (cnt_q == CNT_W'(1));
  assign p_out = t_add_r;

  // Operand load on start, then one multiplier bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      a_q      <= a;
      b_q      <= b;
      acc_q    <= '0;
      cnt_q    <= CNT_W'(W);
      active_q <= 1'b1;
    end else if (active_q) begin
      acc_q <= t_add_r;
      b_q   <= {b_q[W-2:0], 1'b0};
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/twiddle_modexp.sv
// Square-and-multiply modular exponentiation: result = base^exp mod P.
// Handshake: start is sampled only while busy=0; an accepted start latches
// base and exp, busy rises the next cycle and stays high through the done
// cycle. done is a single-cycle pulse and result is valid from that cycle
// until the next done. start while busy=1 is dropped (no queueing).
// Every mulmod takes W+1 cycles and the exponent is scanned over all EXP_W
// bits, so latency depends only on popcount(exp).
module twiddle_modexp
  import ntt_pkg::*;
#(
  parameter int           W     = NTT_W,
  parameter int           EXP_W = NTT_EXP_W,
  parameter logic [W-1:0] P     = NTT_P
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     base,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result,
  output modexp_state_e    state_dbg
);

  localparam int           IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [W-1:0] ONE   = W'(1);

  modexp_state_e    state_q, state_d;
  logic             pend_q, pend_d;
  logic [W-1:0]     base_q, base_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     b_red_q, b_red_d;
  logic [W-1:0]     result_q, result_d;

  logic             mm_start;
  logic [W-1:0]     mm_a;
  logic [W-1:0]     mm_b;
  logic             mm_done;
  logic [W-1:0]     mm_p;

  mod_mul_serial #(
    .W (W),
    .P (P)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .done  (mm_done),
    .p_out (mm_p)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      base_q   <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      b_red_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      b_red_q  <= b_red_d;
      result_q <= result_d;
    end
  end

  // Sequencer: issue one mulmod per state visit, advance on its done.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    base_d   = base_q;
    exp_d    = exp_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    b_red_d  = b_red_q;
    result_d = result_q;
    mm_start = 1'b0;
    mm_a     = acc_q;
    mm_b     = acc_q;

    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (start) begin
          base_d  = base;
          exp_d   = exp;
          idx_d   = IDX_W'(EXP_W - 1);
          acc_d   = ONE;
          state_d = REDUCE;
        end
      end

      REDUCE: begin
        // 1 * base through the multiplier folds any W-bit base below P.
        mm_a = ONE;
        mm_b = base_q;
        if (!pend_q) begin
          mm_start = 1'b1;
          pend_d   = 1'b1;
        end else if (mm_done) begin
          b_red_d = mm_p;
          pend_d  = 1'b0;
          state_d = SQR;
        end
      end

      SQR: begin
        mm_a = acc_q;
        mm_b = acc_q;
        if (!pend_q) begin
          mm_start = 1'b1;
          pend_d   = 1'b1;
        end else if (mm_done) begin
          acc_d  = mm_p;
          pend_d = 1'b0;
          if (exp_q[idx_q]) begin
            state_d = MUL;
          end else if (idx_q == '0) begin
            result_d = mm_p;
            state_d  = FIN;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQR;
          end
        end
      end

      MUL: begin
        mm_a = acc_q;
        mm_b = b_red_q;
        if (!pend_q) begin
          mm_start = 1'b1;
          pend_d   = 1'b1;
        end else if (mm_done) begin
          acc_d  = mm_p;
          pend_d = 1'b0;
          if (idx_q == '0) begin
            result_d = mm_p;
            state_d  = FIN;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQR;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_twiddle_modexp.sv
// Directed and random checks of twiddle_modexp against a plain-arithmetic
// exponentiation model with cycle-accurate busy/done/result expectations.
module tb_twiddle_modexp;
  import ntt_pkg::*;

  localparam int          W      = 64;
  localparam int          EXP_W  = 16;
  localparam int          MM_CYC = W + 1;
  localparam logic [63:0] P      = NTT_P;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     base = '0;
  logic [EXP_W-1:0] exp_val = '0;
  logic             busy;
  logic             done;
  logic [W-1:0]     result;
  modexp_state_e    state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // scoreboard: expected result queue plus timing of the op in flight
  logic [W-1:0] exp_q[$];
  logic         m_active   = 1'b0;
  int           m_c0       = 0;
  int           m_done_cyc = 0;
  logic [W-1:0] hold       = '0;

  twiddle_modexp dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .exp       (exp_val),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  // reference: right-to-left binary exponentiation with wide integers
  function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [15:0] e);
    logic [127:0] r;
    logic [127:0] sq;
    logic [127:0] pw;
    pw = {64'd0, P};
    r  = 128'd1;
    sq = {64'd0, b} % pw;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * sq) % pw;
      sq = (sq * sq) % pw;
    end
    return 64'(r);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, want);
    end
  endtask

  // compare process: every cycle, #1 after the rising edge
  always begin
    logic         exp_done;
    logic         exp_busy;
    logic [W-1:0] want;
    @(posedge clk);
    #1;
    exp_done = m_active && (cyc == m_done_cyc);
    exp_busy = m_active && (cyc >= m_c0) && (cyc <= m_done_cyc);
    if (exp_done) begin
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        hold = want;
      end
    end
    check("done", W'(done), W'(exp_done));
    check("busy", W'(busy), W'(exp_busy));
    check("result", result, hold);
    if (exp_done) m_active = 1'b0;
  end

  // driver tasks
  task automatic wait_idle();
    for (int k = 0; k < 4000 && m_active; k++) @(negedge clk);
    if (m_active) begin
      errors++;
      $display("FAIL idle_timeout cyc=%0d actual=busy required=idle", cyc);
      m_active = 1'b0;
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] b, input logic [EXP_W-1:0] e, input logic [W-1:0] want);
    wait_idle();
    start      = 1'b1;
    base       = b;
    exp_val    = e;
    m_c0       = cyc + 1;
    m_done_cyc = cyc + 1 + (1 + EXP_W + $countones(e)) * MM_CYC;
    m_active   = 1'b1;
    exp_q.push_back(want);
    @(negedge clk);
    start   = 1'b0;
    base    = {$urandom, $urandom};
    exp_val = EXP_W'($urandom_range(0, 65535));
  endtask

  task automatic directed(input logic [W-1:0] b, input logic [EXP_W-1:0] e, input logic [W-1:0] lit);
    check("model_pin", ref_modexp(b, e), lit);
    issue(b, e, lit);
  endtask

  initial begin
    logic [W-1:0]     rb;
    logic [EXP_W-1:0] re;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    directed(NTT_OMEGA, 16'd0, 64'd1);
    directed(64'd2, 16'd10, 64'd1024);
    directed(64'd2, 16'd63, 64'd864691128455135230);
    directed(P + 64'd5, 16'd1, 64'd5);
    directed(P - 64'd1, 16'd2, 64'd1);
    directed(P - 64'd1, 16'd3, 64'd4179340454199820288);
    directed(P, 16'd5, 64'd0);
    directed(64'd0, 16'd0, 64'd1);
    directed(64'd0, 16'd7, 64'd0);
    directed(64'd1, 16'hFFFF, 64'd1);
    directed(P - 64'd1, 16'hFFFF, P - 64'd1);
    directed(64'hFFFF_FFFF_FFFF_FFFF, 16'd1, 64'd1729382256910270459);

    // start pulse during an operation must be dropped
    directed(64'd2, 16'd10, 64'd1024);
    repeat (100) @(negedge clk);
    start   = 1'b1;
    base    = 64'd3;
    exp_val = 16'd1;
    @(negedge clk);
    start = 1'b0;

    // reset in the middle of a run aborts it with no done
    issue(64'd5, 16'h00FF, ref_modexp(64'd5, 16'h00FF));
    repeat (499) @(negedge clk);
    rst      = 1'b1;
    m_active = 1'b0;
    exp_q.delete();
    hold = '0;
    @(negedge clk);
    rst = 1'b0;
    directed(64'd3, 16'd4, 64'd81);

    // random operands, biased toward the modulus boundary
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0:       rb = {$urandom, $urandom};
        1:       rb = P - 64'($urandom_range(0, 3)) + 64'($urandom_range(0, 3));
        default: rb = 64'($urandom_range(0, 1000));
      endcase
      re = EXP_W'($urandom_range(0, 65535));
      issue(rb, re, ref_modexp(rb, re));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
